disp_timing_detect: RTL and testbench



---
 rtl/disp_timing_detect.sv | 276 +++++++++++++++++++++++++++
 tb/tb_disp_timing_detect.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_timing_detect.sv
// -----------------------------------------------------------------------------
// disp_timing_detect
//
// Measures the timing of an incoming hsync/vsync/de stream: pulse width, back
// porch, active size and total size on both axes. It also regenerates pixel
// coordinates aligned to a delayed copy of de and reports lock and error
// status.
//
// Ports
//   i_clk, rst_n            clock, asynchronous active-low reset
//   i_hsync/i_vsync/i_de    incoming sync stream, all active high
//   o_h_*                   horizontal pulse / back porch / active / total (clocks)
//   o_v_*                   vertical pulse / back porch / active / total (lines)
//   o_de                    i_de delayed by two clocks
//   o_x, o_y, o_sof         coordinates and start-of-frame, aligned to o_de
//   o_locked                timing stable for LOCK_FRAMES matching frames
//   o_err                   one-cycle pulse on a timing mismatch while locked
// -----------------------------------------------------------------------------
module disp_timing_detect #(
  parameter int CNT_W       = 12,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             i_clk,
  input  logic             rst_n,
  input  logic             i_hsync,
  input  logic             i_vsync,
  input  logic             i_de,
  output logic [CNT_W-1:0] o_h_pulse,
  output logic [CNT_W-1:0] o_h_bp,
  output logic [CNT_W-1:0] o_h_res,
  output logic [CNT_W-1:0] o_h_total,
  output logic [CNT_W-1:0] o_v_pulse,
  output logic [CNT_W-1:0] o_v_bp,
  output logic [CNT_W-1:0] o_v_res,
  output logic [CNT_W-1:0] o_v_total,
  output logic             o_de,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_sof,
  output logic             o_locked,
  output logic             o_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LOCK_N  = CNT_W'(LOCK_FRAMES);

  // Index of each measurement inside the measurement / snapshot arrays
  localparam int M_HPUL = 0;
  localparam int M_HBP  = 1;
  localparam int M_HRES = 2;
  localparam int M_HTOT = 3;
  localparam int M_VPUL = 4;
  localparam int M_VBP  = 5;
  localparam int M_VRES = 6;
  localparam int M_VTOT = 7;
  localparam int N_MEAS = 8;

  // ---------------------------------------------------------------------------
  // Input registers and edge detection. Bit order: 0 hsync, 1 vsync, 2 de.
  // ---------------------------------------------------------------------------
  logic [2:0] in_q_reg, in_qq_reg;
  logic [2:0] rise, fall;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_edge
      assign rise[gi] = in_q_reg[gi] & ~in_qq_reg[gi];
      assign fall[gi] = ~in_q_reg[gi] & in_qq_reg[gi];
    end
  endgenerate

  logic hs_rise, hs_fall, vs_rise, vs_fall, de_rise, de_fall, de_now;
  assign hs_rise = rise[0];
  assign hs_fall = fall[0];
  assign vs_rise = rise[1];
  assign vs_fall = fall[1];
  assign de_rise = rise[2];
  assign de_fall = fall[2];
  assign de_now  = in_q_reg[2];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] hcnt_reg, hcnt_next;
  logic [CNT_W-1:0] lcnt_reg, lcnt_next;
  logic [CNT_W-1:0] de_start_reg, de_start_next;
  logic [CNT_W-1:0] de_lines_reg, de_lines_next;
  logic [CNT_W-1:0] x_reg, x_next;
  logic [CNT_W-1:0] y_reg, y_next;
  logic             sof_reg, sof_next;
  logic             h_seen_reg, h_seen_next;      // an hs_rise has been seen
  logic             armed_reg, armed_next;        // a vs_rise has been seen
  logic             first_pend_reg, first_pend_next; // next de_rise is frame's first
  logic [CNT_W-1:0] meas_reg [N_MEAS];
  logic [CNT_W-1:0] meas_next[N_MEAS];
  logic [CNT_W-1:0] snap_reg [N_MEAS];
  logic [CNT_W-1:0] snap_next[N_MEAS];
  logic             snap_valid_reg, snap_valid_next;
  logic [CNT_W-1:0] match_reg, match_next;
  logic             err_reg, err_next;

  // ---------------------------------------------------------------------------
  // Counters, coordinates and measurement capture
  // ---------------------------------------------------------------------------
  always_comb begin
    hcnt_next = hs_rise ? ONE : ((hcnt_reg == CNT_MAX) ? hcnt_reg : hcnt_reg + ONE);

    lcnt_next = lcnt_reg;
    if (vs_rise)
      lcnt_next = hs_rise ? ONE : '0;
    else if (hs_rise && lcnt_reg != CNT_MAX)
      lcnt_next = lcnt_reg + ONE;

    de_lines_next = de_lines_reg;
    if (vs_rise)
      de_lines_next = '0;
    else if (de_rise && de_lines_reg != CNT_MAX)
      de_lines_next = de_lines_reg + ONE;

    first_pend_next = first_pend_reg;
    if (vs_rise)
      first_pend_next = 1'b1;
    else if (de_rise)
      first_pend_next = 1'b0;

    x_next = x_reg;
    if (de_rise)
      x_next = '0;
    else if (de_now)
      x_next = x_reg + ONE;

    y_next = y_reg;
    if (de_rise)
      y_next = first_pend_reg ? '0 : y_reg + ONE;

    sof_next    = de_rise & first_pend_reg;
    h_seen_next = h_seen_reg | hs_rise;
    armed_next  = armed_reg | vs_rise;

    // All horizontal captures use hcnt before any reload in this cycle.
    meas_next     = meas_reg;
    de_start_next = de_start_reg;
    if (h_seen_reg) begin
      if (hs_rise)
        meas_next[M_HTOT] = hcnt_reg;
      if (hs_fall)
        meas_next[M_HPUL] = hcnt_reg;
      if (de_rise) begin
        meas_next[M_HBP] = hcnt_reg - meas_reg[M_HPUL];
        de_start_next    = hcnt_reg;
      end
      if (de_fall)
        meas_next[M_HRES] = hcnt_reg - de_start_reg;
    end
    // Vertical measurements belong to a frame opened by a vs_rise.
    if (armed_reg) begin
      if (vs_fall)
        meas_next[M_VPUL] = lcnt_reg;
      if (de_rise && first_pend_reg)
        meas_next[M_VBP] = lcnt_reg - meas_reg[M_VPUL] - ONE;
      if (vs_rise) begin
        meas_next[M_VTOT] = lcnt_reg;
        meas_next[M_VRES] = de_lines_reg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lock tracking. A frame completes on every vs_rise except the arming one;
  // the freshly captured values (meas_next) are compared with the snapshot.
  // ---------------------------------------------------------------------------
  logic [N_MEAS-1:0] meas_eq;
  generate
    for (gi = 0; gi < N_MEAS; gi++) begin : g_cmp
      assign meas_eq[gi] = (meas_next[gi] == snap_reg[gi]);
    end
  endgenerate

  logic locked, frame_done, frame_equal, hs_err, frame_err;
  assign locked      = (match_reg >= LOCK_N);
  assign frame_done  = vs_rise & armed_reg;
  assign frame_equal = snap_valid_reg & (&meas_eq);
  assign hs_err      = locked & hs_rise & h_seen_reg & (hcnt_reg != snap_reg[M_HTOT]);
  assign frame_err   = locked & frame_done & ~frame_equal;

  always_comb begin
    err_next = hs_err | frame_err;

    // On an error the count is held for one cycle and cleared while o_err is
    // high, so o_locked drops the cycle after the error pulse.
    match_next = match_reg;
    if (err_reg)
      match_next = '0;
    else if (err_next)
      match_next = match_reg;
    else if (frame_done)
      match_next = frame_equal ? ((match_reg == CNT_MAX) ? match_reg : match_reg + ONE) : '0;

    snap_next       = snap_reg;
    snap_valid_next = snap_valid_reg;
    if (frame_done) begin
      snap_next       = meas_next;
      snap_valid_next = 1'b1;
    end else if (hs_err) begin
      // Adopt the deviant line length so the disturbed frame cannot match.
      snap_next[M_HTOT] = hcnt_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q_reg       <= '0;
      in_qq_reg      <= '0;
      hcnt_reg       <= '0;
      lcnt_reg       <= '0;
      de_start_reg   <= '0;
      de_lines_reg   <= '0;
      x_reg          <= '0;
      y_reg          <= '0;
      sof_reg        <= 1'b0;
      h_seen_reg     <= 1'b0;
      armed_reg      <= 1'b0;
      first_pend_reg <= 1'b0;
      snap_valid_reg <= 1'b0;
      match_reg      <= '0;
      err_reg        <= 1'b0;
      for (int i = 0; i < N_MEAS; i++) begin
        meas_reg[i] <= '0;
        snap_reg[i] <= '0;
      end
    end else begin
      in_q_reg       <= {i_de, i_vsync, i_hsync};
      in_qq_reg      <= in_q_reg;
      hcnt_reg       <= hcnt_next;
      lcnt_reg       <= lcnt_next;
      de_start_reg   <= de_start_next;
      de_lines_reg   <= de_lines_next;
      x_reg          <= x_next;
      y_reg          <= y_next;
      sof_reg        <= sof_next;
      h_seen_reg     <= h_seen_next;
      armed_reg      <= armed_next;
      first_pend_reg <= first_pend_next;
      snap_valid_reg <= snap_valid_next;
      match_reg      <= match_next;
      err_reg        <= err_next;
      for (int i = 0; i < N_MEAS; i++) begin
        meas_reg[i] <= meas_next[i];
        snap_reg[i] <= snap_next[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_h_pulse = meas_reg[M_HPUL];
  assign o_h_bp    = meas_reg[M_HBP];
  assign o_h_res   = meas_reg[M_HRES];
  assign o_h_total = meas_reg[M_HTOT];
  assign o_v_pulse = meas_reg[M_VPUL];
  assign o_v_bp    = meas_reg[M_VBP];
  assign o_v_res   = meas_reg[M_VRES];
  assign o_v_total = meas_reg[M_VTOT];
  assign o_de      = in_qq_reg[2];
  assign o_x       = x_reg;
  assign o_y       = y_reg;
  assign o_sof     = sof_reg;
  assign o_locked  = locked;
  assign o_err     = err_reg;

endmodule

// File: tb/tb_disp_timing_detect.sv
// -----------------------------------------------------------------------------
// tb_disp_timing_detect
//
// Directed bench for disp_timing_detect. A 13x13 raster (pulse 1, back porch 3,
// active 4, front porch 5 on both axes, hsync/vsync aligned) is generated by
// the bench; expected values are written out by hand from that raster.
// -----------------------------------------------------------------------------
module tb_disp_timing_detect;

  localparam int CNT_W = 12;

  logic             i_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_hsync = 1'b0;
  logic             i_vsync = 1'b0;
  logic             i_de = 1'b0;
  logic [CNT_W-1:0] o_h_pulse, o_h_bp, o_h_res, o_h_total;
  logic [CNT_W-1:0] o_v_pulse, o_v_bp, o_v_res, o_v_total;
  logic             o_de;
  logic [CNT_W-1:0] o_x, o_y;
  logic             o_sof, o_locked, o_err;

  always #5 i_clk = ~i_clk;

  disp_timing_detect #(.CNT_W(CNT_W), .LOCK_FRAMES(2)) dut (
    .i_clk    (i_clk),
    .rst_n    (rst_n),
    .i_hsync  (i_hsync),
    .i_vsync  (i_vsync),
    .i_de     (i_de),
    .o_h_pulse(o_h_pulse),
    .o_h_bp   (o_h_bp),
    .o_h_res  (o_h_res),
    .o_h_total(o_h_total),
    .o_v_pulse(o_v_pulse),
    .o_v_bp   (o_v_bp),
    .o_v_res  (o_v_res),
    .o_v_total(o_v_total),
    .o_de     (o_de),
    .o_x      (o_x),
    .o_y      (o_y),
    .o_sof    (o_sof),
    .o_locked (o_locked),
    .o_err    (o_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Raster generator state: (hc, vc) is the next coordinate to drive.
  int hc = 0, vc = 0;
  int last_hc = 0, last_vc = 0;
  int prev_hc = 0, prev_vc = 0;
  bit prev_valid = 1'b0;
  bit stretch_en = 1'b0;
  bit coord_en   = 1'b0;
  bit mon_en     = 1'b0;
  int de_count = 0, mon_err_cycles = 0, mon_unlock_cycles = 0;

  function automatic bit gen_de(int h, int v);
    return (h >= 4) && (h < 8) && (v >= 4) && (v < 8);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one raster cycle, then sample 1 time unit after the clock edge.
  // At that point the outputs reflect the cycle driven one step earlier.
  task automatic gen_step();
    bit e;
    int len;
    i_hsync = (hc == 0);
    i_vsync = (vc == 0);
    i_de    = gen_de(hc, vc);
    last_hc = hc;
    last_vc = vc;
    @(posedge i_clk);
    #1;
    if (coord_en) begin
      e = prev_valid && gen_de(prev_hc, prev_vc);
      check("o_de", o_de, e);
      check("o_sof", o_sof, e && prev_hc == 4 && prev_vc == 4);
      if (e) begin
        de_count++;
        check("o_x", o_x, prev_hc - 4);
        check("o_y", o_y, prev_vc - 4);
      end
    end
    if (mon_en) begin
      if (o_err !== 1'b0)    mon_err_cycles++;
      if (o_locked !== 1'b1) mon_unlock_cycles++;
    end
    prev_hc    = hc;
    prev_vc    = vc;
    prev_valid = 1'b1;
    len = (stretch_en && vc == 6) ? 14 : 13;
    hc++;
    if (hc >= len) begin
      hc = 0;
      vc = (vc == 12) ? 0 : vc + 1;
    end
  endtask

  // Step until coordinate (h, v) has just been driven.
  task automatic run_to(input int h, input int v);
    int guard;
    guard = 0;
    do begin
      gen_step();
      guard++;
    end while (!(last_hc == h && last_vc == v) && guard < 4000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(posedge i_clk);
    #1;
    check("reset h_total", o_h_total, 0);
    check("reset v_total", o_v_total, 0);
    check("reset locked", o_locked, 0);
    check("reset err", o_err, 0);
    check("reset de", o_de, 0);
    rst_n = 1'b1;

    // ---------------- first vs_rise only arms ----------------
    run_to(1, 0);
    check("arm v_total", o_v_total, 0);
    check("arm locked", o_locked, 0);

    // ---------------- second vs_rise: full measurement ----------------
    run_to(1, 0);
    check("h_pulse", o_h_pulse, 1);
    check("h_bp", o_h_bp, 3);
    check("h_res", o_h_res, 4);
    check("h_total", o_h_total, 13);
    check("v_pulse", o_v_pulse, 1);
    check("v_bp", o_v_bp, 3);
    check("v_res", o_v_res, 4);
    check("v_total", o_v_total, 13);
    check("locked vs2", o_locked, 0);

    // ---------------- lock after 4th vs_rise ----------------
    run_to(1, 0);
    check("locked vs3", o_locked, 0);
    run_to(0, 0);
    check("locked vs4-1", o_locked, 0);
    gen_step();
    check("locked vs4", o_locked, 1);

    // ---------------- coordinates + 10 locked frames ----------------
    mon_en   = 1'b1;
    coord_en = 1'b1;
    de_count = 0;
    run_to(1, 0);
    coord_en = 1'b0;
    check("de cycles per frame", de_count, 16);
    for (int f = 0; f < 9; f++) run_to(1, 0);
    mon_en = 1'b0;
    check("err cycles while locked", mon_err_cycles, 0);
    check("unlocked cycles", mon_unlock_cycles, 0);

    // ---------------- one line stretched to 14 clocks ----------------
    stretch_en = 1'b1;
    run_to(0, 7);
    stretch_en = 1'b0;
    check("glitch err before", o_err, 0);
    check("glitch locked before", o_locked, 1);
    gen_step();
    check("glitch err pulse", o_err, 1);
    check("glitch h_total", o_h_total, 14);
    check("glitch locked same cycle", o_locked, 1);
    gen_step();
    check("glitch err end", o_err, 0);
    check("glitch unlocked", o_locked, 0);
    run_to(1, 0);
    check("relock frame0", o_locked, 0);
    run_to(1, 0);
    check("relock frame1", o_locked, 0);
    check("relock h_total", o_h_total, 13);
    run_to(0, 0);
    check("relock frame2-1", o_locked, 0);
    gen_step();
    check("relock frame2", o_locked, 1);

    // ---------------- asynchronous reset mid active line ----------------
    run_to(5, 5);
    check("pre-reset de", o_de, 1);
    check("pre-reset y", o_y, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async h_total", o_h_total, 0);
    check("async h_bp", o_h_bp, 0);
    check("async v_total", o_v_total, 0);
    check("async y", o_y, 0);
    check("async de", o_de, 0);
    check("async locked", o_locked, 0);
    repeat (3) gen_step();
    rst_n = 1'b1;
    run_to(1, 0);
    check("rearm v_total", o_v_total, 0);
    check("rearm v_res", o_v_res, 0);
    check("rearm locked", o_locked, 0);
    run_to(1, 0);
    check("rearm vs2 v_total", o_v_total, 13);
    check("rearm vs2 locked", o_locked, 0);
    run_to(1, 0);
    check("rearm vs3 locked", o_locked, 0);
    run_to(0, 0);
    check("rearm vs4-1 locked", o_locked, 0);
    gen_step();
    check("rearm vs4 locked", o_locked, 1);

    // ---------------- hcnt saturation ----------------
    i_hsync = 1'b0;
    i_vsync = 1'b0;
    i_de    = 1'b0;
    repeat (5000) @(posedge i_clk);
    #1;
    check("hold h_total", o_h_total, 13);
    check("hold v_total", o_v_total, 13);
    i_hsync = 1'b1;
    @(posedge i_clk);
    #1;
    i_hsync = 1'b0;
    @(posedge i_clk);
    #1;
    check("sat h_total", o_h_total, 4095);
    check("sat err", o_err, 1);
    @(posedge i_clk);
    #1;
    check("sat err end", o_err, 0);
    check("sat unlocked", o_locked, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
